// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load and memory-side signals of the shared read port.
// The arbiter takes the slave view; requesters and memory drive the master view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        if_err;

    logic        ld_req;
    logic [63:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [63:0] ld_rdata;
    logic        ld_err;

    logic        mem_req;
    logic [63:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_valid;

    modport slave (
        input  if_req, if_addr,
        input  ld_req, ld_addr, ld_size,
        input  mem_ready, mem_rdata, mem_valid,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ld_gnt, ld_rvalid, ld_rdata, ld_err,
        output mem_req, mem_addr, mem_size
    );

    modport master (
        output if_req, if_addr,
        output ld_req, ld_addr, ld_size,
        output mem_ready, mem_rdata, mem_valid,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
        input  mem_req, mem_addr, mem_size
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-at-a-time sharing of the memory read port (fetch vs load).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention (default: load first).
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } owner_e;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        cnt_hit;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        gnt_q, gnt_d;
    logic        pick_ld;
    logic        resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e      last_q, last_d;
`endif

    assign cnt_inc = cnt_q + 16'd1;
    assign cnt_hit = (cnt_inc == 16'(TIMEOUT_CYCLES));

    // Choose the winner when sampling requests in IDLE.
    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_ld = bus.ld_req && (!bus.if_req || (last_q == OWN_IF));
`else
        pick_ld = bus.ld_req;
`endif
    end

    // Next-state logic: capture, issue, wait with timeout, respond.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        gnt_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.ld_req) begin
                    owner_d = pick_ld ? OWN_LD : OWN_IF;
                    addr_d  = pick_ld ? bus.ld_addr : bus.if_addr;
                    size_d  = pick_ld ? bus.ld_size : 2'b11;
                    gnt_d   = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d  = pick_ld ? OWN_LD : OWN_IF;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_ready) begin
                    cnt_d   = 16'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (bus.mem_valid) begin
                    // Loads get their operand aligned down to bit 0.
                    if (owner_q == OWN_LD) begin
                        rdata_d = bus.mem_rdata >> {addr_q[2:0], 3'b000};
                    end else begin
                        rdata_d = bus.mem_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_hit) begin
                    rdata_d = 64'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-transaction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            addr_q  <= 64'd0;
            size_q  <= 2'b00;
            cnt_q   <= 16'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember who was granted last for round-robin fairness.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign resp = (state_q == S_RESP);
    assign busy = (state_q != S_IDLE);

    assign bus.mem_req  = (state_q == S_ISSUE);
    assign bus.mem_addr = {addr_q[63:3], 3'b000};
    assign bus.mem_size = size_q;

    assign bus.if_gnt = gnt_q && (owner_q == OWN_IF);
    assign bus.ld_gnt = gnt_q && (owner_q == OWN_LD);

    assign bus.if_rvalid = resp && (owner_q == OWN_IF);
    assign bus.ld_rvalid = resp && (owner_q == OWN_LD);

    // Data and error are only driven during the owner's response pulse.
    assign bus.if_rdata = bus.if_rvalid ? rdata_q : 64'd0;
    assign bus.ld_rdata = bus.ld_rvalid ? rdata_q : 64'd0;
    assign bus.if_err   = bus.if_rvalid && err_q;
    assign bus.ld_err   = bus.ld_rvalid && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter (TIMEOUT_CYCLES=4).
// Build with MEM_ARB_ROUND_ROBIN_EN to check the round-robin order.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   total = 0;
    int   bad = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        logic exp_ld;
        logic seen;

        reset         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 64'd0;
        bus.ld_req    = 1'b0;
        bus.ld_addr   = 64'd0;
        bus.ld_size   = 2'b00;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 64'd0;
        bus.mem_valid = 1'b0;

        // reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_gnt", {bus.if_gnt, bus.ld_gnt}, 0);
        chk("rst_rvalid", {bus.if_rvalid, bus.ld_rvalid}, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // single byte load at 0x1003
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 64'h1003;
        bus.ld_size   = 2'b00;
        bus.mem_ready = 1'b1;
        tick();
        chk("ld_gnt", bus.ld_gnt, 1);
        chk("ld_if_gnt", bus.if_gnt, 0);
        chk("ld_mem_req", bus.mem_req, 1);
        chk("ld_mem_addr", bus.mem_addr, 64'h1000);
        chk("ld_mem_size", bus.mem_size, 0);
        chk("ld_busy", busy, 1);
        bus.ld_req = 1'b0;
        tick();
        chk("ld_gnt_pulse", bus.ld_gnt, 0);
        chk("ld_mem_req_off", bus.mem_req, 0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 64'h8877665544332211;
        tick();
        bus.mem_valid = 1'b0;
        bus.mem_ready = 1'b0;
        chk("ld_rvalid", bus.ld_rvalid, 1);
        chk("ld_rdata", bus.ld_rdata, 64'h0000008877665544);
        chk("ld_err", bus.ld_err, 0);
        chk("ld_if_rvalid", bus.if_rvalid, 0);
        tick();
        chk("ld_rvalid_pulse", bus.ld_rvalid, 0);
        chk("ld_idle", busy, 0);

        // fetch with mem_ready delayed
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h2000;
        tick();
        chk("if_gnt", bus.if_gnt, 1);
        chk("if_mem_size", bus.mem_size, 3);
        chk("if_mem_addr", bus.mem_addr, 64'h2000);
        bus.if_req = 1'b0;
        n = 0;
        while (bus.mem_req && n < 10) begin
            n++;
            if (n == 4) bus.mem_ready = 1'b1;
            tick();
        end
        chk("if_mem_req_cycles", n, 4);
        bus.mem_ready = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 64'hdeadbeefcafef00d;
        tick();
        bus.mem_valid = 1'b0;
        chk("if_rvalid", bus.if_rvalid, 1);
        chk("if_rdata", bus.if_rdata, 64'hdeadbeefcafef00d);
        chk("if_err", bus.if_err, 0);
        chk("if_ld_rvalid", bus.ld_rvalid, 0);
        tick();
        chk("if_rvalid_pulse", bus.if_rvalid, 0);

        // simultaneous requests, four transactions
        bus.if_req    = 1'b1;
        bus.if_addr   = 64'h7000;
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 64'h8000;
        bus.ld_size   = 2'b11;
        bus.mem_ready = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 64'h0123456789abcdef;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_ld = (k % 2 == 0);
`else
            exp_ld = 1'b1;
`endif
            n = 0;
            while (!(bus.if_gnt || bus.ld_gnt) && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("arb_gnt_seen%0d", k), n < 20, 1);
            chk($sformatf("arb_ld_gnt%0d", k), bus.ld_gnt, exp_ld);
            chk($sformatf("arb_if_gnt%0d", k), bus.if_gnt, !exp_ld);
            n = 0;
            while (!(bus.if_rvalid || bus.ld_rvalid) && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("arb_ld_rv%0d", k), bus.ld_rvalid, exp_ld);
            chk($sformatf("arb_if_rv%0d", k), bus.if_rvalid, !exp_ld);
            tick();
        end
        bus.if_req    = 1'b0;
        bus.ld_req    = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        chk("arb_idle", busy, 0);

        // timeout after 4 WAIT cycles
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 64'h3005;
        bus.ld_size   = 2'b10;
        bus.mem_ready = 1'b1;
        tick();
        chk("to_gnt", bus.ld_gnt, 1);
        bus.ld_req = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        n = 0;
        while (!bus.ld_rvalid && n < 10) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 4);
        chk("to_rvalid", bus.ld_rvalid, 1);
        chk("to_err", bus.ld_err, 1);
        chk("to_rdata", bus.ld_rdata, 0);
        tick();
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 64'haaaa5555aaaa5555;
        tick();
        bus.mem_valid = 1'b0;
        chk("to_late_busy", busy, 0);
        chk("to_late_rvalid", {bus.if_rvalid, bus.ld_rvalid}, 0);
        tick();

        // mem_valid on the same cycle the limit is reached
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 64'h4002;
        bus.ld_size   = 2'b01;
        bus.mem_ready = 1'b1;
        tick();
        bus.ld_req = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | bus.ld_rvalid;
        end
        chk("bnd_early_rvalid", seen, 0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 64'h1122334455667788;
        tick();
        bus.mem_valid = 1'b0;
        chk("bnd_rvalid", bus.ld_rvalid, 1);
        chk("bnd_err", bus.ld_err, 0);
        chk("bnd_rdata", bus.ld_rdata, 64'h0000112233445566);
        tick();

        // asynchronous reset during WAIT
        bus.if_req    = 1'b1;
        bus.if_addr   = 64'h5008;
        bus.mem_ready = 1'b1;
        tick();
        bus.if_req = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        chk("rw_busy_wait", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_mem_req", bus.mem_req, 0);
        chk("rw_mem_addr", bus.mem_addr, 0);
        chk("rw_rvalid", {bus.if_rvalid, bus.ld_rvalid}, 0);
        #1;
        reset = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 64'h0f0f0f0f0f0f0f0f;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.mem_valid = 1'b0;
            seen = seen | bus.if_rvalid | bus.ld_rvalid;
        end
        chk("rw_no_rvalid", seen, 0);
        bus.if_req    = 1'b1;
        bus.if_addr   = 64'h6000;
        bus.mem_ready = 1'b1;
        tick();
        chk("rw_if_gnt", bus.if_gnt, 1);
        bus.if_req = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 64'hfedcba9876543210;
        tick();
        bus.mem_valid = 1'b0;
        chk("rw_if_rvalid", bus.if_rvalid, 1);
        chk("rw_if_rdata", bus.if_rdata, 64'hfedcba9876543210);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
